// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage: PC, imem req/ack, IF/ID register, redirect squash
//
// Purpose:
//   Owns the PC, issues req/ack fetches to the instruction memory and holds the
//   IF/ID register. A set_pc redirect flushes IF/ID and reloads the PC. A fetch
//   already in flight keeps its address until it is acked and is then discarded.
//   A fetch that completes while decode is stalled parks in a one-entry skid.
//
// Ports:
//   clk             in   rising-edge clock
//   rst             in   asynchronous active-low reset
//   stall           in   hold IF/ID contents
//   set_pc          in   redirect request
//   set_pc_value    in   redirect target
//   imem_req        out  fetch request, held until imem_ack
//   imem_addr       out  fetch address, stable while imem_req=1
//   imem_ack        in   single-cycle fetch completion
//   imem_data       in   fetched instruction
//   if_inst         out  IF/ID instruction (NOP_INST when invalid)
//   if_npc          out  IF/ID fetch PC + 1
//   if_valid        out  IF/ID holds a real instruction
//   perf_fetch_cnt  out  accepted fetches, saturating (IF_PERF_EN only)
//   perf_squash_cnt out  redirect cycles, saturating (IF_PERF_EN only)
//
// Optional feature macro: IF_PERF_EN

module if_stage #(
    parameter int              WIDTH    = 16,
    parameter logic [WIDTH-1:0] RESET_PC = 16'h0000,
    parameter logic [WIDTH-1:0] NOP_INST = 16'h0800
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             set_pc,
    input  logic [WIDTH-1:0] set_pc_value,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_ack,
    input  logic [WIDTH-1:0] imem_data,
    output logic [WIDTH-1:0] if_inst,
    output logic [WIDTH-1:0] if_npc,
    output logic             if_valid
`ifdef IF_PERF_EN
    ,
    output logic [15:0]      perf_fetch_cnt,
    output logic [15:0]      perf_squash_cnt
`endif
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_HOLD  = 2'd1,
        S_KILL  = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_pc;
    logic             r_req;
    logic [WIDTH-1:0] r_addr;
    logic [WIDTH-1:0] r_inst;
    logic [WIDTH-1:0] r_npc;
    logic             r_valid;
    logic [WIDTH-1:0] r_skid_inst;
    logic [WIDTH-1:0] r_skid_npc;

    state_t           w_nxt_state;
    logic [WIDTH-1:0] w_nxt_pc;
    logic             w_nxt_req;
    logic [WIDTH-1:0] w_nxt_addr;
    logic [WIDTH-1:0] w_nxt_inst;
    logic [WIDTH-1:0] w_nxt_npc;
    logic             w_nxt_valid;
    logic [WIDTH-1:0] w_nxt_skid_inst;
    logic [WIDTH-1:0] w_nxt_skid_npc;
    logic             w_ack;
    logic             w_accept;
    logic [WIDTH-1:0] w_pc_inc;

    // An ack only counts while a request is actually on the bus.
    assign w_ack    = imem_ack & r_req;
    // Natural wrap modulo 2^WIDTH.
    assign w_pc_inc = r_pc + WIDTH'(1);

    always_comb begin
        w_nxt_state     = r_state;
        w_nxt_pc        = r_pc;
        w_nxt_inst      = r_inst;
        w_nxt_npc       = r_npc;
        w_nxt_valid     = r_valid;
        w_nxt_skid_inst = r_skid_inst;
        w_nxt_skid_npc  = r_skid_npc;
        w_accept        = 1'b0;

        if (set_pc) begin
            // Redirect beats stall: flush IF/ID and drop any parked fetch.
            w_nxt_pc        = set_pc_value;
            w_nxt_inst      = NOP_INST;
            w_nxt_valid     = 1'b0;
            w_nxt_skid_inst = NOP_INST;
            w_nxt_skid_npc  = '0;
            // An unacked request must keep its address until it completes.
            if (r_req && !imem_ack) begin
                w_nxt_state = S_KILL;
            end else begin
                w_nxt_state = S_FETCH;
            end
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (w_ack) begin
                        w_accept = 1'b1;
                        w_nxt_pc = w_pc_inc;
                        if (stall) begin
                            w_nxt_skid_inst = imem_data;
                            w_nxt_skid_npc  = w_pc_inc;
                            w_nxt_state     = S_HOLD;
                        end else begin
                            w_nxt_inst  = imem_data;
                            w_nxt_npc   = w_pc_inc;
                            w_nxt_valid = 1'b1;
                        end
                    end else if (!stall) begin
                        // Decode consumed the old entry and nothing new arrived.
                        w_nxt_inst  = NOP_INST;
                        w_nxt_valid = 1'b0;
                    end
                end
                S_HOLD: begin
                    if (!stall) begin
                        w_nxt_inst      = r_skid_inst;
                        w_nxt_npc       = r_skid_npc;
                        w_nxt_valid     = 1'b1;
                        w_nxt_skid_inst = NOP_INST;
                        w_nxt_skid_npc  = '0;
                        w_nxt_state     = S_FETCH;
                    end
                end
                S_KILL: begin
                    // Wrong-path data is dropped; pc already holds the target.
                    if (w_ack) begin
                        w_nxt_state = S_FETCH;
                    end
                    if (!stall) begin
                        w_nxt_inst  = NOP_INST;
                        w_nxt_valid = 1'b0;
                    end
                end
                default: begin
                    w_nxt_state = S_FETCH;
                end
            endcase
        end

        w_nxt_req  = (w_nxt_state != S_HOLD);
        w_nxt_addr = (w_nxt_state == S_KILL) ? r_addr : w_nxt_pc;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_FETCH;
            r_pc        <= RESET_PC;
            r_req       <= 1'b0;
            r_addr      <= RESET_PC;
            r_inst      <= NOP_INST;
            r_npc       <= '0;
            r_valid     <= 1'b0;
            r_skid_inst <= NOP_INST;
            r_skid_npc  <= '0;
        end else begin
            r_state     <= w_nxt_state;
            r_pc        <= w_nxt_pc;
            r_req       <= w_nxt_req;
            r_addr      <= w_nxt_addr;
            r_inst      <= w_nxt_inst;
            r_npc       <= w_nxt_npc;
            r_valid     <= w_nxt_valid;
            r_skid_inst <= w_nxt_skid_inst;
            r_skid_npc  <= w_nxt_skid_npc;
        end
    end

    assign imem_req  = r_req;
    assign imem_addr = r_addr;
    assign if_inst   = r_inst;
    assign if_npc    = r_npc;
    assign if_valid  = r_valid;

`ifdef IF_PERF_EN
    logic [15:0] r_fetch_cnt;
    logic [15:0] r_squash_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fetch_cnt  <= '0;
            r_squash_cnt <= '0;
        end else begin
            if (w_accept && (r_fetch_cnt != 16'hFFFF)) begin
                r_fetch_cnt <= r_fetch_cnt + 16'd1;
            end
            if (set_pc && (r_squash_cnt != 16'hFFFF)) begin
                r_squash_cnt <= r_squash_cnt + 16'd1;
            end
        end
    end

    assign perf_fetch_cnt  = r_fetch_cnt;
    assign perf_squash_cnt = r_squash_cnt;
`endif

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - self-checking bench for if_stage

module tb_if_stage;

    localparam logic [15:0] NOP = 16'h0800;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic        set_pc = 1'b0;
    logic [15:0] set_pc_value = 16'h0000;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [15:0] imem_data = 16'h0000;
    logic [15:0] if_inst;
    logic [15:0] if_npc;
    logic        if_valid;
`ifdef IF_PERF_EN
    logic [15:0] perf_fetch_cnt;
    logic [15:0] perf_squash_cnt;
`endif

    if_stage dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .set_pc       (set_pc),
        .set_pc_value (set_pc_value),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_data    (imem_data),
        .if_inst      (if_inst),
        .if_npc       (if_npc),
        .if_valid     (if_valid)
`ifdef IF_PERF_EN
        ,
        .perf_fetch_cnt  (perf_fetch_cnt),
        .perf_squash_cnt (perf_squash_cnt)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Memory responder state: waits per request drawn from [mem_lo, mem_hi].
    int mem_lo  = 0;
    int mem_hi  = 0;
    int mem_cnt = 0;
    int mem_cur = 0;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return 16'h4000 + a;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Decide the memory's response for the coming edge from the request on the bus.
    task automatic mem_eval();
        if (!rst || !imem_req) begin
            imem_ack = 1'b0;
            mem_cnt  = 0;
        end else if (mem_cnt >= mem_cur) begin
            imem_ack  = 1'b1;
            imem_data = mem_word(imem_addr);
            mem_cnt   = 0;
            mem_cur   = int'($urandom_range(mem_hi, mem_lo));
        end else begin
            imem_ack = 1'b0;
            mem_cnt++;
        end
    endtask

    task automatic tick();
        mem_eval();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " rst req"},   16'(imem_req), 16'h0);
        chk({tag, " rst addr"},  imem_addr, 16'h0000);
        chk({tag, " rst inst"},  if_inst, NOP);
        chk({tag, " rst npc"},   if_npc, 16'h0000);
        chk({tag, " rst valid"}, 16'(if_valid), 16'h0);
`ifdef IF_PERF_EN
        chk({tag, " rst perf_fetch"},  perf_fetch_cnt, 16'h0);
        chk({tag, " rst perf_squash"}, perf_squash_cnt, 16'h0);
`endif
    endtask

    task automatic reset_hold(input int lo, input int hi);
        rst          = 1'b0;
        stall        = 1'b0;
        set_pc       = 1'b0;
        set_pc_value = 16'h0000;
        imem_ack     = 1'b0;
        mem_lo       = lo;
        mem_hi       = hi;
        mem_cnt      = 0;
        mem_cur      = lo;
        @(posedge clk);
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        stall;
        logic        set_pc;
        logic [15:0] spv;
        logic        e_req;
        logic [15:0] e_addr;
        logic        c_addr;
        logic [15:0] e_inst;
        logic [15:0] e_npc;
        logic        c_npc;
        logic        e_valid;
    } vec_t;

    vec_t tbl[$];

    initial begin
        int kill_ticks;
        int n;
        int delivered;
        logic [15:0] exp_pc;
        logic        p_req;
        logic [15:0] p_addr;
        logic [15:0] p_inst;
        logic [15:0] p_npc;
        logic        p_valid;
        logic        r_stall;
        logic        r_set;
        logic [15:0] r_spv;

        // Zero-wait memory stream, stall into skid, flush beating stall, PC wrap.
        //               stall set  spv       req  addr     ca   inst      npc      cn   valid
        tbl.push_back('{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b1, NOP,      16'h0000, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0001, 1'b1, 16'h4000, 16'h0001, 1'b1, 1'b1});
        tbl.push_back('{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0002, 1'b1, 16'h4001, 16'h0002, 1'b1, 1'b1});
        tbl.push_back('{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0003, 1'b1, 16'h4002, 16'h0003, 1'b1, 1'b1});
        tbl.push_back('{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0004, 1'b1, 16'h4003, 16'h0004, 1'b1, 1'b1});
        tbl.push_back('{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0005, 1'b1, 16'h4004, 16'h0005, 1'b1, 1'b1});
        tbl.push_back('{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h4004, 16'h0005, 1'b1, 1'b1});
        tbl.push_back('{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h4004, 16'h0005, 1'b1, 1'b1});
        tbl.push_back('{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h4004, 16'h0005, 1'b1, 1'b1});
        tbl.push_back('{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0006, 1'b1, 16'h4005, 16'h0006, 1'b1, 1'b1});
        tbl.push_back('{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0007, 1'b1, 16'h4006, 16'h0007, 1'b1, 1'b1});
        tbl.push_back('{1'b1, 1'b1, 16'h0200, 1'b1, 16'h0200, 1'b1, NOP,      16'h0000, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0201, 1'b1, 16'h4200, 16'h0201, 1'b1, 1'b1});
        tbl.push_back('{1'b0, 1'b1, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, NOP,      16'h0000, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b1, 16'h3FFF, 16'h0000, 1'b1, 1'b1});
        tbl.push_back('{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0001, 1'b1, 16'h4000, 16'h0001, 1'b1, 1'b1});

        reset_hold(0, 0);
        chk_reset("init");
        rst = 1'b1;
        for (int i = 0; i < tbl.size(); i++) begin
            stall        = tbl[i].stall;
            set_pc       = tbl[i].set_pc;
            set_pc_value = tbl[i].spv;
            tick();
            chk($sformatf("vec%0d req", i), 16'(imem_req), 16'(tbl[i].e_req));
            if (tbl[i].c_addr) chk($sformatf("vec%0d addr", i), imem_addr, tbl[i].e_addr);
            chk($sformatf("vec%0d inst", i), if_inst, tbl[i].e_inst);
            if (tbl[i].c_npc) chk($sformatf("vec%0d npc", i), if_npc, tbl[i].e_npc);
            chk($sformatf("vec%0d valid", i), 16'(if_valid), 16'(tbl[i].e_valid));
        end
        stall  = 1'b0;
        set_pc = 1'b0;
`ifdef IF_PERF_EN
        chk("perf_fetch after table", perf_fetch_cnt, 16'd10);
        chk("perf_squash after table", perf_squash_cnt, 16'd2);
`endif

        // Redirect while a 3-wait-state fetch of address 8 is outstanding.
        reset_hold(0, 0);
        rst = 1'b1;
        tick();
        mem_lo       = 3;
        mem_hi       = 3;
        set_pc       = 1'b1;
        set_pc_value = 16'h0008;
        tick();
        chk("kill setup addr", imem_addr, 16'h0008);
        set_pc_value = 16'h0100;
        tick();
        set_pc = 1'b0;
        chk("kill enter req", 16'(imem_req), 16'h1);
        chk("kill enter addr", imem_addr, 16'h0008);
        chk("kill enter valid", 16'(if_valid), 16'h0);
        kill_ticks = 0;
        while (imem_addr == 16'h0008 && kill_ticks < 10) begin
            tick();
            kill_ticks++;
            chk("kill req held", 16'(imem_req), 16'h1);
            chk("kill no mem8", 16'(if_inst == 16'h4008), 16'h0);
            chk("kill bubble valid", 16'(if_valid), 16'h0);
        end
        chk("kill wait cycles", 16'(kill_ticks), 16'd3);
        chk("kill new addr", imem_addr, 16'h0100);
        n = 0;
        while (!if_valid && n < 10) begin
            tick();
            n++;
            chk("target no mem8", 16'(if_inst == 16'h4008), 16'h0);
        end
        chk("target latency", 16'(n), 16'd4);
        chk("target inst", if_inst, 16'h4100);
        chk("target npc", if_npc, 16'h0101);

        // Reset asserted while in the kill state.
        set_pc       = 1'b1;
        set_pc_value = 16'h0300;
        tick();
        set_pc = 1'b0;
        chk("kill2 addr", imem_addr, 16'h0101);
        chk("kill2 req", 16'(imem_req), 16'h1);
        #3;
        rst = 1'b0;
        #1;
        chk_reset("midkill");
        mem_lo  = 0;
        mem_hi  = 0;
        mem_cnt = 0;
        mem_cur = 0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        tick();
        chk("post-rst req", 16'(imem_req), 16'h1);
        chk("post-rst addr", imem_addr, 16'h0000);
        tick();
        chk("post-rst inst", if_inst, 16'h4000);
        chk("post-rst npc", if_npc, 16'h0001);
        chk("post-rst valid", 16'(if_valid), 16'h1);

        // Random stall/redirect/wait-state traffic against a program-order model.
        reset_hold(0, 2);
        rst       = 1'b1;
        exp_pc    = 16'h0000;
        delivered = 0;
        for (int c = 0; c < 600; c++) begin
            r_stall = ($urandom_range(0, 99) < 30);
            r_set   = ($urandom_range(0, 99) < 5);
            r_spv   = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
            stall        = r_stall;
            set_pc       = r_set;
            set_pc_value = r_spv;
            p_req   = imem_req;
            p_addr  = imem_addr;
            p_inst  = if_inst;
            p_npc   = if_npc;
            p_valid = if_valid;
            tick();
            if (p_req && !imem_ack && imem_req) begin
                chk("rnd addr stable", imem_addr, p_addr);
            end
            if (r_set) begin
                exp_pc = r_spv;
                chk("rnd flush valid", 16'(if_valid), 16'h0);
                chk("rnd flush inst", if_inst, NOP);
            end else if (r_stall) begin
                chk("rnd hold valid", 16'(if_valid), 16'(p_valid));
                chk("rnd hold inst", if_inst, p_inst);
                chk("rnd hold npc", if_npc, p_npc);
            end else if (if_valid) begin
                chk("rnd order npc", if_npc, exp_pc + 16'd1);
                chk("rnd order inst", if_inst, mem_word(exp_pc));
                exp_pc = exp_pc + 16'd1;
                delivered++;
            end else begin
                chk("rnd bubble inst", if_inst, NOP);
            end
        end
        stall  = 1'b0;
        set_pc = 1'b0;
        chk("rnd progress", 16'(delivered >= 60), 16'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

endmodule
